// File: rtl/adxl345_pkg.sv
// rtl/adxl345_pkg.sv - ADXL345 register map, reset values and frame command types
package adxl345_pkg;

    localparam logic [5:0] ADDR_DEVID       = 6'h00;
    localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
    localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
    localparam logic [5:0] ADDR_INT_SOURCE  = 6'h30;
    localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
    localparam logic [5:0] ADDR_DATAX0      = 6'h32;
    localparam logic [5:0] ADDR_DATAX1      = 6'h33;
    localparam logic [5:0] ADDR_DATAY0      = 6'h34;
    localparam logic [5:0] ADDR_DATAY1      = 6'h35;
    localparam logic [5:0] ADDR_DATAZ0      = 6'h36;
    localparam logic [5:0] ADDR_DATAZ1      = 6'h37;
    localparam logic [5:0] ADDR_FIFO_CTL    = 6'h38;

    localparam logic [7:0] RST_BW_RATE     = 8'h0A;
    localparam logic [7:0] RST_POWER_CTL   = 8'h00;
    localparam logic [7:0] RST_DATA_FORMAT = 8'h00;
    localparam logic [7:0] RST_FIFO_CTL    = 8'h00;

    typedef enum logic {
        REG_WRITE = 1'b0,
        REG_READ  = 1'b1
    } reg_dir_t;

    typedef struct packed {
        logic       rw;
        logic       mb;
        logic [5:0] addr;
    } frame_cmd_t;

    function automatic logic is_data_reg(input logic [5:0] a);
        return (a >= ADDR_DATAX0) && (a <= ADDR_DATAZ1);
    endfunction

    function automatic logic is_read_only(input logic [5:0] a);
        return (a == ADDR_DEVID) || (a == ADDR_INT_SOURCE) || is_data_reg(a);
    endfunction

endpackage

// File: rtl/spi_target_shifter.sv
// rtl/spi_target_shifter.sv - mode-3 SPI target front end: synchronizers, edge detect, byte shifting
module spi_target_shifter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sck_i,
    input  logic       cs_n_i,
    input  logic       mosi_i,
    input  logic [7:0] tx_byte_i,
    output logic       cs_low_o,
    output logic       byte_done_o,
    output logic [7:0] byte_data_o,
    output logic       miso_o
);

    logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
    logic       sck_prev_q, armed_q, miso_q;
    logic [2:0] bit_cnt_q;
    logic [6:0] rx_q;
    logic [7:0] tx_q;
    logic       sck_s, cs_s, mosi_s, cs_low, sck_rise, sck_fall;

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // A frame is only honoured once cs_n has been seen high since reset.
    assign cs_low   = armed_q & ~cs_s;
    assign sck_rise = cs_low & sck_s & ~sck_prev_q;
    assign sck_fall = cs_low & ~sck_s & sck_prev_q;

    assign cs_low_o    = cs_low;
    assign byte_done_o = sck_rise && (bit_cnt_q == 3'd7);
    assign byte_data_o = {rx_q, mosi_s};
    assign miso_o      = miso_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync_q  <= '1;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b1;
            armed_q     <= 1'b0;
            bit_cnt_q   <= 3'd0;
            rx_q        <= 7'd0;
            tx_q        <= 8'd0;
            miso_q      <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            sck_prev_q  <= sck_s;
            if (cs_s) armed_q <= 1'b1;
            if (!cs_low) begin
                bit_cnt_q <= 3'd0;
                miso_q    <= 1'b0;
            end else begin
                if (sck_rise) begin
                    rx_q      <= {rx_q[5:0], mosi_s};
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                end
                // First fall of each byte loads the freshly fetched byte.
                if (sck_fall) begin
                    if (bit_cnt_q == 3'd0) begin
                        miso_q <= tx_byte_i[7];
                        tx_q   <= {tx_byte_i[6:0], 1'b0};
                    end else begin
                        miso_q <= tx_q[7];
                        tx_q   <= {tx_q[6:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule

// File: rtl/adxl345_spi_responder.sv
// rtl/adxl345_spi_responder.sv - ADXL345 register-file SPI target with AXI-Stream sample input
module adxl345_spi_responder
    import adxl345_pkg::*;
#(
    parameter logic [7:0] DEVID_VALUE  = 8'hE5,
    parameter int         SYNC_STAGES  = 2,
    parameter int         SAMPLE_WIDTH = 48
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    spi_sck,
    input  logic                    spi_cs_n,
    input  logic                    spi_mosi,
    output logic                    spi_miso,
    output logic                    spi_miso_oe,
    input  logic [SAMPLE_WIDTH-1:0] sample_tdata,
    input  logic                    sample_tvalid,
    output logic                    sample_tready,
    output logic                    reg_write_valid,
    output logic [5:0]              reg_write_addr,
    output logic [7:0]              reg_write_data,
    output logic                    measuring
);

    typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} state_t;

    state_t     state_q;
    reg_dir_t   rw_q;
    logic       mb_q;
    logic [5:0] addr_q;
    logic [7:0] rd_byte_q;
    logic [7:0] regs_q [64];
    logic       tready_q, wr_valid_q, measuring_q;
    logic [5:0] wr_addr_q;
    logic [7:0] wr_data_q;

    logic       cs_low, byte_done, miso;
    logic [7:0] byte_data;
    frame_cmd_t cmd;
    logic [5:0] next_addr;

    spi_target_shifter #(.SYNC_STAGES(SYNC_STAGES)) u_shifter (
        .clk         (clk),
        .reset       (reset),
        .sck_i       (spi_sck),
        .cs_n_i      (spi_cs_n),
        .mosi_i      (spi_mosi),
        .tx_byte_i   (rd_byte_q),
        .cs_low_o    (cs_low),
        .byte_done_o (byte_done),
        .byte_data_o (byte_data),
        .miso_o      (miso)
    );

    assign cmd       = frame_cmd_t'(byte_data);
    assign next_addr = mb_q ? addr_q + 6'd1 : addr_q;

    assign spi_miso        = miso;
    assign spi_miso_oe     = cs_low;
    assign sample_tready   = tready_q;
    assign reg_write_valid = wr_valid_q;
    assign reg_write_addr  = wr_addr_q;
    assign reg_write_data  = wr_data_q;
    assign measuring       = measuring_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rw_q        <= REG_WRITE;
            mb_q        <= 1'b0;
            addr_q      <= 6'd0;
            rd_byte_q   <= 8'd0;
            tready_q    <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= 6'd0;
            wr_data_q   <= 8'd0;
            measuring_q <= 1'b0;
            for (int i = 0; i < 64; i++) regs_q[i] <= 8'h00;
            regs_q[ADDR_DEVID]       <= DEVID_VALUE;
            regs_q[ADDR_BW_RATE]     <= RST_BW_RATE;
            regs_q[ADDR_POWER_CTL]   <= RST_POWER_CTL;
            regs_q[ADDR_DATA_FORMAT] <= RST_DATA_FORMAT;
            regs_q[ADDR_FIFO_CTL]    <= RST_FIFO_CTL;
        end else begin
            wr_valid_q  <= 1'b0;
            measuring_q <= regs_q[ADDR_POWER_CTL][3];
            // Only offered while idle and deselected, so data regs are frozen within a frame.
            tready_q    <= (state_q == ST_IDLE) && !cs_low;
            if (!cs_low) begin
                state_q   <= ST_IDLE;
                rd_byte_q <= 8'd0;
            end else begin
                case (state_q)
                    ST_IDLE: state_q <= ST_CMD;
                    ST_CMD: if (byte_done) begin
                        rw_q      <= reg_dir_t'(cmd.rw);
                        mb_q      <= cmd.mb;
                        addr_q    <= cmd.addr;
                        rd_byte_q <= cmd.rw ? regs_q[cmd.addr] : 8'd0;
                        state_q   <= ST_DATA;
                    end
                    ST_DATA: if (byte_done) begin
                        if (rw_q == REG_WRITE) begin
                            if (!is_read_only(addr_q)) begin
                                regs_q[addr_q] <= byte_data;
                                wr_valid_q     <= 1'b1;
                                wr_addr_q      <= addr_q;
                                wr_data_q      <= byte_data;
                            end
                        end else begin
                            if (is_data_reg(addr_q)) regs_q[ADDR_INT_SOURCE][7] <= 1'b0;
                            rd_byte_q <= regs_q[next_addr];
                        end
                        addr_q <= next_addr;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
            if (sample_tvalid && tready_q) begin
                regs_q[ADDR_DATAX0]         <= sample_tdata[7:0];
                regs_q[ADDR_DATAX1]         <= sample_tdata[15:8];
                regs_q[ADDR_DATAY0]         <= sample_tdata[23:16];
                regs_q[ADDR_DATAY1]         <= sample_tdata[31:24];
                regs_q[ADDR_DATAZ0]         <= sample_tdata[39:32];
                regs_q[ADDR_DATAZ1]         <= sample_tdata[47:40];
                regs_q[ADDR_INT_SOURCE][7]  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adxl345_spi_responder.sv
// tb/tb_adxl345_spi_responder.sv - randomized self-checking bench with register-map reference model
module tb_adxl345_spi_responder;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        spi_sck = 1'b1, spi_cs_n = 1'b1, spi_mosi = 1'b0;
    logic        spi_miso, spi_miso_oe;
    logic [47:0] sample_tdata = '0;
    logic        sample_tvalid = 1'b0;
    logic        sample_tready, reg_write_valid, measuring;
    logic [5:0]  reg_write_addr;
    logic [7:0]  reg_write_data;

    int errors = 0;
    int checks = 0;

    logic [7:0]  tx_buf[$];
    logic [7:0]  rx_buf[$];
    logic [7:0]  exp_rx[$];
    logic [13:0] exp_wr[$];
    logic [13:0] wr_log[$];
    logic [7:0]  mem[64];
    logic        oe_mid;

    adxl345_spi_responder dut (
        .clk             (clk),
        .reset           (reset),
        .spi_sck         (spi_sck),
        .spi_cs_n        (spi_cs_n),
        .spi_mosi        (spi_mosi),
        .spi_miso        (spi_miso),
        .spi_miso_oe     (spi_miso_oe),
        .sample_tdata    (sample_tdata),
        .sample_tvalid   (sample_tvalid),
        .sample_tready   (sample_tready),
        .reg_write_valid (reg_write_valid),
        .reg_write_addr  (reg_write_addr),
        .reg_write_data  (reg_write_data),
        .measuring       (measuring)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (reg_write_valid) wr_log.push_back({reg_write_addr, reg_write_data});

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        mem[0]     = 8'hE5;
        mem[6'h2C] = 8'h0A;
    endtask

    function automatic bit read_only(input int a);
        return a == 0 || a == 'h30 || (a >= 'h32 && a <= 'h37);
    endfunction

    task automatic model_sample(input logic [47:0] d);
        for (int i = 0; i < 6; i++) mem['h32 + i] = d[8*i +: 8];
        mem['h30][7] = 1'b1;
    endtask

    // Expected MISO bytes and committed writes for the complete bytes of tx_buf.
    task automatic model_frame(input int nbytes);
        logic [7:0] c;
        int a;
        exp_rx.delete();
        exp_wr.delete();
        c = tx_buf[0];
        a = int'(c[5:0]);
        exp_rx.push_back(8'h00);
        for (int i = 1; i < nbytes; i++) begin
            if (c[7]) begin
                exp_rx.push_back(mem[a]);
                if (a >= 'h32 && a <= 'h37) mem['h30][7] = 1'b0;
            end else begin
                exp_rx.push_back(8'h00);
                if (!read_only(a)) begin
                    mem[a] = tx_buf[i];
                    exp_wr.push_back({a[5:0], tx_buf[i]});
                end
            end
            if (c[6]) a = (a + 1) % 64;
        end
    endtask

    task automatic spi_frame(input int nbits);
        logic [7:0] cur = 8'h00;
        rx_buf.delete();
        @(negedge clk) spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            spi_sck  = 1'b0;
            spi_mosi = tx_buf[b/8][7 - (b % 8)];
            repeat (HALF) @(negedge clk);
            if (b == 0) oe_mid = spi_miso_oe;
            cur = {cur[6:0], spi_miso};
            spi_sck = 1'b1;
            if (b % 8 == 7) rx_buf.push_back(cur);
            repeat (HALF) @(negedge clk);
        end
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        repeat (3 * HALF) @(negedge clk);
    endtask

    task automatic run_frame(input string tag, input int nbits);
        model_frame(nbits / 8);
        wr_log.delete();
        spi_frame(nbits);
        for (int i = 0; i < exp_rx.size(); i++)
            check($sformatf("%s_rx%0d", tag, i), rx_buf[i], exp_rx[i]);
        check($sformatf("%s_nwr", tag), wr_log.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), wr_log[i], exp_wr[i]);
        check($sformatf("%s_meas", tag), measuring, mem['h2D][3]);
    endtask

    task automatic frame2(input string tag, input logic [7:0] b0, input logic [7:0] b1);
        tx_buf.delete();
        tx_buf.push_back(b0);
        tx_buf.push_back(b1);
        run_frame(tag, 16);
    endtask

    task automatic sample_push(input logic [47:0] d);
        bit ok = 1'b0;
        sample_tdata  = d;
        sample_tvalid = 1'b1;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (sample_tready) ok = 1'b1;
        end
        @(negedge clk);
        sample_tvalid = 1'b0;
        check("sample_accept", ok, 1'b1);
        if (ok) model_sample(d);
    endtask

    initial begin
        model_reset();
        repeat (4) @(negedge clk);
        check("rst_oe", spi_miso_oe, 1'b0);
        check("rst_miso", spi_miso, 1'b0);
        check("rst_wv", reg_write_valid, 1'b0);
        check("rst_meas", measuring, 1'b0);
        check("rst_tready", sample_tready, 1'b0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        frame2("devid", 8'h80, 8'h00);
        check("devid_byte", rx_buf[1], 8'hE5);
        check("oe_in_frame", oe_mid, 1'b1);
        check("oe_after", spi_miso_oe, 1'b0);

        frame2("pwr_wr", 8'h2D, 8'h08);
        check("measure_on", measuring, 1'b1);
        frame2("pwr_rd", 8'hAD, 8'h00);

        sample_push(48'h0605_0403_0201);
        frame2("drdy_set", 8'hB0, 8'h00);
        tx_buf.delete();
        tx_buf.push_back(8'hF2);
        for (int i = 0; i < 6; i++) tx_buf.push_back(8'h00);
        run_frame("mb_read", 56);
        frame2("drdy_clr", 8'hB0, 8'h00);

        frame2("devid_wr", 8'h00, 8'h12);
        frame2("devid_rd", 8'h80, 8'h00);
        tx_buf.delete();
        tx_buf.push_back(8'h7F);
        tx_buf.push_back(8'hAA);
        tx_buf.push_back(8'hBB);
        run_frame("wrap_wr", 24);

        tx_buf.delete();
        tx_buf.push_back(8'h31);
        tx_buf.push_back(8'h55);
        fork
            run_frame("partial", 12);
            begin
                wait (spi_cs_n == 1'b0);
                repeat (20) @(negedge clk);
                sample_tdata  = 48'h0C0B_0A09_0807;
                sample_tvalid = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    repeat (10) @(negedge clk);
                    check("tready_in_frame", sample_tready, 1'b0);
                end
            end
        join
        sample_push(48'h0C0B_0A09_0807);
        frame2("fmt_rd", 8'hB1, 8'h00);
        frame2("data_rd", 8'hB2, 8'h00);

        // Reset in the middle of a DEVID read.
        @(negedge clk) spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int b = 0; b < 12; b++) begin
            spi_sck  = 1'b0;
            spi_mosi = (b == 0);
            repeat (HALF) @(negedge clk);
            spi_sck = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        spi_sck = 1'b0;
        repeat (HALF) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_miso", spi_miso, 1'b0);
        check("midrst_oe", spi_miso_oe, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("midrst_oe_hold", spi_miso_oe, 1'b0);
        spi_sck  = 1'b1;
        spi_cs_n = 1'b1;
        model_reset();
        repeat (10) @(negedge clk);
        frame2("post_rst", 8'h80, 8'h00);

        for (int it = 0; it < 40; it++) begin
            int n;
            if ($urandom_range(0, 2) == 0) sample_push({$urandom(), $urandom()});
            n = $urandom_range(1, 4);
            tx_buf.delete();
            tx_buf.push_back(8'($urandom()));
            for (int i = 0; i < n; i++) tx_buf.push_back(8'($urandom()));
            run_frame($sformatf("rnd%0d", it), 8 * (n + 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
